i2c_reg_ctrl: RTL

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

---
 rtl/mppt_reg_pkg.sv | 29 ++
 rtl/i2c_reg_ctrl_read_mux.sv | 48 ++++
 rtl/i2c_reg_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mppt_reg_pkg.sv
// mppt_reg_pkg: register map addresses, status bit positions and commit FSM encoding
package mppt_reg_pkg;
    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h01;
    localparam logic [7:0] A_STEP_H = 8'h02;
    localparam logic [7:0] A_STEP_L = 8'h03;
    localparam logic [7:0] A_VMAX_H = 8'h04;
    localparam logic [7:0] A_VMAX_L = 8'h05;
    localparam logic [7:0] A_VMIN_H = 8'h06;
    localparam logic [7:0] A_VMIN_L = 8'h07;
    localparam logic [7:0] A_VREF_H = 8'h08;
    localparam logic [7:0] A_PVV_H  = 8'h0A;
    localparam logic [7:0] A_PVI_H  = 8'h0C;
    localparam logic [7:0] A_BATV_H = 8'h0E;
    localparam logic [7:0] A_BATI_H = 8'h10;
    localparam logic [7:0] A_T1_H   = 8'h12;
    localparam logic [7:0] A_T2_H   = 8'h14;
    localparam logic [7:0] A_LAST   = 8'h15;

    localparam int ST_ERR  = 7;
    localparam int ST_PEND = 6;
    localparam int ST_CFGV = 5;

    typedef enum logic [1:0] {C_IDLE, C_PEND, C_REQ} commit_state_t;

    function automatic logic [7:0] pair_base(input logic [7:0] a);
        return {a[7:1], 1'b0};
    endfunction
endpackage

// File: rtl/i2c_reg_ctrl_read_mux.sv
// reg_read_mux: combinational decode of a register byte address to its read byte
module reg_read_mux
    import mppt_reg_pkg::*;
(
    input  logic [7:0]  addr,
    input  logic [7:0]  ctrl,
    input  logic [7:0]  status,
    input  logic [15:0] step_size,
    input  logic [15:0] v_max,
    input  logic [15:0] v_min,
    input  logic [15:0] v_ref,
    input  logic [15:0] pv_v,
    input  logic [15:0] pv_i,
    input  logic [15:0] bat_v,
    input  logic [15:0] bat_i,
    input  logic [15:0] temp1,
    input  logic [15:0] temp2,
    input  logic        shadow_valid,
    input  logic [7:0]  shadow_tag,
    input  logic [7:0]  shadow_data,
    output logic [7:0]  rd_byte,
    output logic [7:0]  low_byte
);
    logic [15:0] word;
    logic        shadow_hit;

    always_comb begin
        case (pair_base(addr))
            A_STEP_H: word = step_size;
            A_VMAX_H: word = v_max;
            A_VMIN_H: word = v_min;
            A_VREF_H: word = v_ref;
            A_PVV_H:  word = pv_v;
            A_PVI_H:  word = pv_i;
            A_BATV_H: word = bat_v;
            A_BATI_H: word = bat_i;
            A_T1_H:   word = temp1;
            A_T2_H:   word = temp2;
            default:  word = 16'h0000;
        endcase
        shadow_hit = shadow_valid && shadow_tag == pair_base(addr);
        low_byte   = word[7:0];
        rd_byte    = addr == A_CTRL   ? ctrl :
                     addr == A_STATUS ? status :
                     !addr[0]         ? word[15:8] :
                     shadow_hit       ? shadow_data : word[7:0];
    end
endmodule

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: I2C-facing MPPT register file with split 16-bit commits and a cfg handshake.
// Define CFG_RANGE_CHECK_EN to reject commits leaving v_min >= v_max or step_size == 0.
module i2c_reg_ctrl #(
    parameter logic [7:0]  CTRL_DEF = 8'h00,
    parameter logic [15:0] STEP_DEF = 16'h0010,
    parameter logic [15:0] VMAX_DEF = 16'hE000,
    parameter logic [15:0] VMIN_DEF = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        reg_write,
    input  logic        reg_read,
    output logic [7:0]  reg_rdata,
    output logic [7:0]  ctrl,
    output logic [15:0] step_size,
    output logic [15:0] v_max,
    output logic [15:0] v_min,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    input  logic [7:0]  core_status,
    input  logic [15:0] v_ref,
    input  logic [15:0] pv_v,
    input  logic [15:0] pv_i,
    input  logic [15:0] bat_v,
    input  logic [15:0] bat_i,
    input  logic [15:0] temp1,
    input  logic [15:0] temp2
);
    import mppt_reg_pkg::*;

    commit_state_t state, state_nxt;
    logic        pend_valid, pend_nxt, err_sticky;
    logic [7:0]  pend_tag, pend_data;
    logic        shadow_valid;
    logic [7:0]  shadow_tag, shadow_data;
    logic [7:0]  status, rd_byte, low_byte;
    logic        wr_ctrl, wr_even, wr_odd, wr_bad, match, commit16, range_ok;
    logic        commit, reject, wr_err, rd_snap, rd_status;
    logic [15:0] new_word, nstep, nvmax, nvmin;

    always_comb begin
        wr_ctrl   = reg_write && reg_addr == A_CTRL;
        wr_even   = reg_write && (reg_addr == A_STEP_H || reg_addr == A_VMAX_H || reg_addr == A_VMIN_H);
        wr_odd    = reg_write && (reg_addr == A_STEP_L || reg_addr == A_VMAX_L || reg_addr == A_VMIN_L);
        wr_bad    = reg_write && !wr_ctrl && !wr_even && !wr_odd;
        match     = pend_valid && pend_tag == pair_base(reg_addr);
        commit16  = wr_odd && match;
        new_word  = {pend_data, reg_wdata};
        nstep     = commit16 && reg_addr == A_STEP_L ? new_word : step_size;
        nvmax     = commit16 && reg_addr == A_VMAX_L ? new_word : v_max;
        nvmin     = commit16 && reg_addr == A_VMIN_L ? new_word : v_min;
`ifdef CFG_RANGE_CHECK_EN
        range_ok  = nstep != 16'h0000 && nvmin < nvmax;
`else
        range_ok  = 1'b1;
`endif
        commit    = wr_ctrl || (commit16 && range_ok);
        reject    = commit16 && !range_ok;
        wr_err    = wr_bad || (wr_odd && !match) || reject;
        pend_nxt  = wr_even ? 1'b1 : wr_odd ? 1'b0 : pend_valid;
        rd_snap   = reg_read && !reg_addr[0] && reg_addr >= A_STEP_H && reg_addr <= A_LAST;
        rd_status = reg_read && reg_addr == A_STATUS;
        status    = {3'b000, core_status[4:0]};
        status[ST_ERR]  = err_sticky;
        status[ST_PEND] = pend_valid;
        status[ST_CFGV] = cfg_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= C_IDLE;
        else        state <= state_nxt;
    end

    // A held high byte survives a handshake, so C_REQ falls back to C_PEND when one is waiting
    always_comb begin
        case (state)
            C_IDLE:  state_nxt = wr_ctrl ? C_REQ : wr_even ? C_PEND : C_IDLE;
            C_PEND:  state_nxt = commit ? C_REQ : wr_odd ? C_IDLE : C_PEND;
            C_REQ:   state_nxt = reject ? C_IDLE : commit ? C_REQ :
                                 cfg_ready ? (pend_nxt ? C_PEND : C_IDLE) : C_REQ;
            default: state_nxt = C_IDLE;
        endcase
    end

    always_comb cfg_valid = state == C_REQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl         <= CTRL_DEF;
            step_size    <= STEP_DEF;
            v_max        <= VMAX_DEF;
            v_min        <= VMIN_DEF;
            reg_rdata    <= 8'h00;
            err_sticky   <= 1'b0;
            pend_valid   <= 1'b0;
            pend_tag     <= 8'h00;
            pend_data    <= 8'h00;
            shadow_valid <= 1'b0;
            shadow_tag   <= 8'h00;
            shadow_data  <= 8'h00;
        end else begin
            if (wr_ctrl) ctrl <= reg_wdata;
            if (commit16 && range_ok) begin
                step_size <= nstep;
                v_max     <= nvmax;
                v_min     <= nvmin;
            end
            pend_valid <= pend_nxt;
            if (wr_even) begin
                pend_tag  <= reg_addr;
                pend_data <= reg_wdata;
            end
            err_sticky <= wr_err || (err_sticky && !rd_status);
            if (reg_read) reg_rdata <= rd_byte;
            if (rd_snap) begin
                shadow_valid <= 1'b1;
                shadow_tag   <= reg_addr;
                shadow_data  <= low_byte;
            end
        end
    end

    reg_read_mux u_mux (
        .addr         (reg_addr),
        .ctrl         (ctrl),
        .status       (status),
        .step_size    (step_size),
        .v_max        (v_max),
        .v_min        (v_min),
        .v_ref        (v_ref),
        .pv_v         (pv_v),
        .pv_i         (pv_i),
        .bat_v        (bat_v),
        .bat_i        (bat_i),
        .temp1        (temp1),
        .temp2        (temp2),
        .shadow_valid (shadow_valid),
        .shadow_tag   (shadow_tag),
        .shadow_data  (shadow_data),
        .rd_byte      (rd_byte),
        .low_byte     (low_byte)
    );
endmodule
